rv32imf_regfile_sb: RTL and testbench
=====================================

# rv32imf_regfile_sb

Parametrised successor to the core's integer/FP register file. It provides N read ports and M write ports over a unified address space: the MSB selects the FP bank, and x0 is hardwired to zero. It adds optional same-cycle write-to-read bypass and a per-register pending-write scoreboard. The scoreboard lets the issue stage stall on RAW hazards when writebacks from multi-cycle units (MUL/DIV/FPU) are still outstanding. It sits between the ID stage (reads, marks) and the WB/LSU/FPU writeback paths.

## Interface
- ADDR_WIDTH, 6, register address width; bit ADDR_WIDTH-1 = 1 selects the FP bank; each bank holds 2**(ADDR_WIDTH-1) words.
- DATA_WIDTH, 32, register width.
- NUM_RD, 3, number of read ports (1..4).
- NUM_WR, 2, number of write ports (1..4).
- BYPASS, 1, 1 = a read returns write data presented in the same cycle.
- FP_ENABLE, 1, 0 = no FP bank is instantiated.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset, asynchronous, active-low.
- raddr_i  in  NUM_RD*ADDR_WIDTH  read addresses; port k uses slice k.
- rdata_o  out  NUM_RD*DATA_WIDTH  read data; combinational.
- rbusy_o  out  NUM_RD  addressed register has a pending write; combinational.
- waddr_i  in  NUM_WR*ADDR_WIDTH  write addresses.
- wdata_i  in  NUM_WR*DATA_WIDTH  write data.
- we_i  in  NUM_WR  write enables.
- mark_i  in  1  issue of an instruction that will write mark_addr_i later.
- mark_addr_i  in  ADDR_WIDTH  destination being reserved.
- flush_i  in  1  clear all busy bits (pipeline kill).
- busy_cnt_o  out  ADDR_WIDTH+1  number of busy registers; registered.

## Operation
- Storage: integer bank mem[0..W-1] and FP bank mem_fp[0..W-1]. The busy vector busy[0..2W-1] has one bit per address.
- x0 (address 0):
  - always reads 0 and is never busy;
  - writes to it are dropped, and so are marks on it.
- FP_ENABLE=0:
  - reads of FP addresses return 0 with rbusy 0;
  - writes and marks to FP addresses are ignored.
- Write conflict: if several enabled write ports target the same address, the highest-index port wins. The other writes to that address are dropped.
- Write effect: at the clock edge the data is stored and busy[addr] is cleared.
- Mark effect: at the clock edge busy[mark_addr_i] is set.
  - If a mark and a write hit the same address in the same cycle, data is stored and busy ends SET, because the mark is a newer producer.
- Flush:
  - clears every busy bit at the edge; register data is unaffected;
  - takes priority over a same-cycle mark, so the mark is discarded;
  - same-cycle writes still store data.
- Read, BYPASS=0: rdata is the stored value; rbusy = busy[addr].
- Read, BYPASS=1: if any enabled write port targets addr (addr != 0), rdata is the winning port's wdata and rbusy = 0. Otherwise the BYPASS=0 behaviour applies.
- busy_cnt_o equals the popcount of the busy vector after the edge, i.e. it is registered and tracks busy with no lag beyond the edge.

## Timing
- Reset:
  - all integer and FP registers are 0, all busy bits are 0, busy_cnt_o = 0;
  - rdata_o and rbusy_o are therefore 0 for every address.
- Write latency:
  - BYPASS=0: write data is readable in cycle N+1;
  - BYPASS=1: write data is readable in cycle N via the combinational bypass, and from the array in N+1.
- Mark latency: a mark in cycle N makes rbusy = 1 for that address from cycle N+1 until the edge that writes it or a flush.
- A reset assertion mid-operation clears all state immediately (asynchronously) and discards in-flight writes. The first write accepted after deassertion lands on the first rising edge with rst_n = 1.
- There are no handshakes: writes and marks are always accepted. The issue stage must stall on rbusy_o.

## Test plan
- Reset, then read addresses 0, 5 and 33 on all ports -> rdata = 0, rbusy = 0, busy_cnt_o = 0.
- Write 0xDEADBEEF to x7 on port 0 and 0x12345678 to f1 (addr 33) on port 1, with a same-cycle read of x7:
  - BYPASS=1 -> 0xDEADBEEF in the same cycle;
  - BYPASS=0 -> old value 0 in the same cycle, 0xDEADBEEF the next cycle;
  - f1 reads 0x12345678 the next cycle.
- Ports 0 and 1 both write x3 (0x1111 / 0x2222) -> x3 = 0x2222; write 0xFFFF to x0 -> x0 reads 0.
- Mark x10 -> rbusy = 1 and busy_cnt_o = 1 next cycle; three cycles later write x10 = 0xA5 -> rbusy = 0, busy_cnt_o = 0, data = 0xA5.
- Mark x12 and write x12 = 0x55 in the same cycle -> data = 0x55, busy still 1, busy_cnt_o = 1.
- Mark x4, x5 and f2, then flush with a same-cycle mark on x6 -> busy_cnt_o = 0, no register busy.
- Assert rst_n low mid-stream -> all outputs are 0 within the same cycle, without waiting for a clock edge.

Source files
------------

// File: rtl/rv32imf_regfile_sb.sv
// rv32imf_regfile_sb: unified int/FP register file with optional write bypass and pending-write scoreboard
module rv32imf_regfile_sb #(
  parameter int ADDR_WIDTH = 6,
  parameter int DATA_WIDTH = 32,
  parameter int NUM_RD     = 3,
  parameter int NUM_WR     = 2,
  parameter int BYPASS     = 1,
  parameter int FP_ENABLE  = 1
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [NUM_RD*ADDR_WIDTH-1:0] raddr_i,
  output logic [NUM_RD*DATA_WIDTH-1:0] rdata_o,
  output logic [NUM_RD-1:0]            rbusy_o,
  input  logic [NUM_WR*ADDR_WIDTH-1:0] waddr_i,
  input  logic [NUM_WR*DATA_WIDTH-1:0] wdata_i,
  input  logic [NUM_WR-1:0]            we_i,
  input  logic                         mark_i,
  input  logic [ADDR_WIDTH-1:0]        mark_addr_i,
  input  logic                         flush_i,
  output logic [ADDR_WIDTH:0]          busy_cnt_o
);
  localparam int N = 2**ADDR_WIDTH;
  logic [DATA_WIDTH-1:0] mem [N];
  logic [N-1:0]          busy, busy_nxt;
  logic [ADDR_WIDTH-1:0] wa [NUM_WR];
  logic [DATA_WIDTH-1:0] wd [NUM_WR];
  logic [NUM_WR-1:0]     wv;
  logic                  mv;
  logic [ADDR_WIDTH:0]   cnt_nxt;

  // x0 and (when disabled) the FP bank are never written, so they always read 0 and never go busy
  function automatic logic ok(input logic [ADDR_WIDTH-1:0] a);
    return a != '0 && (FP_ENABLE != 0 || !a[ADDR_WIDTH-1]);
  endfunction

  for (genvar w = 0; w < NUM_WR; w++) begin : g_wr
    assign wa[w] = waddr_i[w*ADDR_WIDTH +: ADDR_WIDTH];
    assign wd[w] = wdata_i[w*DATA_WIDTH +: DATA_WIDTH];
    assign wv[w] = we_i[w] && ok(wa[w]);
  end
  assign mv = mark_i && ok(mark_addr_i);

  // Writes retire producers, a mark is the newer producer so it is applied last, flush overrides all
  always_comb begin
    busy_nxt = busy;
    for (int p = 0; p < NUM_WR; p++) if (wv[p]) busy_nxt[wa[p]] = 1'b0;
    if (mv) busy_nxt[mark_addr_i] = 1'b1;
    if (flush_i) busy_nxt = '0;
  end

  // Popcount of the next busy vector so the registered count has no extra lag
  always_comb begin
    cnt_nxt = '0;
    for (int i = 0; i < N; i++) cnt_nxt = cnt_nxt + {{ADDR_WIDTH{1'b0}}, busy_nxt[i]};
  end

  // Array and scoreboard state; ascending port order lets the highest-index writer win
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < N; i++) mem[i] <= '0;
      busy       <= '0;
      busy_cnt_o <= '0;
    end else begin
      for (int p = 0; p < NUM_WR; p++) if (wv[p]) mem[wa[p]] <= wd[p];
      busy       <= busy_nxt;
      busy_cnt_o <= cnt_nxt;
    end
  end

  for (genvar k = 0; k < NUM_RD; k++) begin : g_rd
    logic [ADDR_WIDTH-1:0] a;
    logic                  hit;
    logic [DATA_WIDTH-1:0] byp;
    assign a = raddr_i[k*ADDR_WIDTH +: ADDR_WIDTH];
    // Same-cycle bypass from the winning (highest-index) write port
    always_comb begin
      hit = 1'b0;
      byp = '0;
      for (int p = 0; p < NUM_WR; p++) if (BYPASS != 0 && wv[p] && wa[p] == a) begin
        hit = 1'b1;
        byp = wd[p];
      end
    end
    assign rdata_o[k*DATA_WIDTH +: DATA_WIDTH] = hit ? byp : mem[a];
    assign rbusy_o[k] = !hit && busy[a];
  end
endmodule

// File: tb/tb_rv32imf_regfile_sb.sv
// tb_rv32imf_regfile_sb: directed + random checks of bypass and non-bypass register files against an array model
module tb_rv32imf_regfile_sb;
  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [5:0]  ra [3];
  logic [5:0]  wa [2];
  logic [31:0] wd [2];
  logic [1:0]  we;
  logic        mark, flush;
  logic [5:0]  maddr;
  logic [17:0] raddr;
  logic [11:0] waddr;
  logic [63:0] wdata;
  logic [95:0] rdata1, rdata0;
  logic [2:0]  rbusy1, rbusy0;
  logic [6:0]  cnt1, cnt0;
  logic [31:0] m_mem [64];
  bit          m_busy [64];
  int          n_cmp = 0, n_err = 0;

  assign raddr = {ra[2], ra[1], ra[0]};
  assign waddr = {wa[1], wa[0]};
  assign wdata = {wd[1], wd[0]};

  always #5 clk = ~clk;

  rv32imf_regfile_sb #(.BYPASS(1)) u_byp (
    .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata1), .rbusy_o(rbusy1),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .mark_i(mark), .mark_addr_i(maddr),
    .flush_i(flush), .busy_cnt_o(cnt1));

  rv32imf_regfile_sb #(.BYPASS(0)) u_nob (
    .clk(clk), .rst_n(rst_n), .raddr_i(raddr), .rdata_o(rdata0), .rbusy_o(rbusy0),
    .waddr_i(waddr), .wdata_i(wdata), .we_i(we), .mark_i(mark), .mark_addr_i(maddr),
    .flush_i(flush), .busy_cnt_o(cnt0));

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  function automatic int m_count();
    int c = 0;
    for (int i = 0; i < 64; i++) c += int'(m_busy[i]);
    return c;
  endfunction

  function automatic bit byp_hit(input logic [5:0] a);
    bit h = 0;
    for (int p = 0; p < 2; p++) if (we[p] && wa[p] == a && a != 0) h = 1;
    return h;
  endfunction

  function automatic logic [31:0] byp_val(input logic [5:0] a);
    logic [31:0] v = '0;
    for (int p = 0; p < 2; p++) if (we[p] && wa[p] == a && a != 0) v = wd[p];
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < 64; i++) begin
      m_mem[i] = '0;
      m_busy[i] = 0;
    end
  endtask

  task automatic model_edge();
    for (int p = 0; p < 2; p++) if (we[p] && wa[p] != 0) begin
      m_mem[wa[p]] = wd[p];
      m_busy[wa[p]] = 0;
    end
    if (mark && maddr != 0) m_busy[maddr] = 1;
    if (flush) for (int i = 0; i < 64; i++) m_busy[i] = 0;
  endtask

  task automatic check_outputs();
    for (int k = 0; k < 3; k++) begin
      bit h = byp_hit(ra[k]);
      check($sformatf("rd_byp[%0d] a=%0d", k, ra[k]), rdata1[k*32 +: 32], h ? byp_val(ra[k]) : m_mem[ra[k]]);
      check($sformatf("bz_byp[%0d] a=%0d", k, ra[k]), rbusy1[k], h ? 1'b0 : m_busy[ra[k]]);
      check($sformatf("rd_nob[%0d] a=%0d", k, ra[k]), rdata0[k*32 +: 32], m_mem[ra[k]]);
      check($sformatf("bz_nob[%0d] a=%0d", k, ra[k]), rbusy0[k], m_busy[ra[k]]);
    end
    check("cnt_byp", cnt1, 64'(m_count()));
    check("cnt_nob", cnt0, 64'(m_count()));
  endtask

  task automatic tick();
    @(negedge clk);
    check_outputs();
    @(posedge clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    we = '0;
    mark = 0;
    flush = 0;
  endtask

  function automatic logic [5:0] rnd_addr();
    return {1'($urandom_range(0, 1)), 5'($urandom_range(0, 7))};
  endfunction

  initial begin
    idle();
    maddr = '0;
    wa[0] = '0; wa[1] = '0; wd[0] = '0; wd[1] = '0;
    ra[0] = 6'd0; ra[1] = 6'd5; ra[2] = 6'd33;
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst_n = 1;
    check("reset_cnt", cnt1, 0);
    tick();

    we = 2'b11; wa[0] = 6'd7; wd[0] = 32'hDEADBEEF; wa[1] = 6'd33; wd[1] = 32'h12345678;
    ra[0] = 6'd7; ra[1] = 6'd33; ra[2] = 6'd7;
    #1;
    check("x7_bypass_same", rdata1[31:0], 32'hDEADBEEF);
    check("x7_nobyp_same", rdata0[31:0], 32'h0);
    tick();
    idle();
    #1;
    check("x7_nobyp_next", rdata0[31:0], 32'hDEADBEEF);
    check("f1_next", rdata0[63:32], 32'h12345678);
    tick();

    we = 2'b11; wa[0] = 6'd3; wd[0] = 32'h1111; wa[1] = 6'd3; wd[1] = 32'h2222;
    ra[0] = 6'd3;
    tick();
    we = 2'b01; wa[0] = 6'd0; wd[0] = 32'hFFFF; ra[0] = 6'd0; ra[1] = 6'd3;
    #1;
    check("x0_bypass", rdata1[31:0], 32'h0);
    check("x3_conflict", rdata0[63:32], 32'h2222);
    tick();
    idle();
    tick();

    mark = 1; maddr = 6'd10; ra[0] = 6'd10;
    tick();
    idle();
    #1;
    check("x10_busy", rbusy1[0], 1'b1);
    check("x10_cnt", cnt1, 1);
    repeat (2) tick();
    we = 2'b01; wa[0] = 6'd10; wd[0] = 32'hA5;
    tick();
    idle();
    #1;
    check("x10_free", rbusy0[0], 1'b0);
    check("x10_cnt0", cnt0, 0);
    check("x10_data", rdata0[31:0], 32'hA5);
    tick();

    mark = 1; maddr = 6'd12; we = 2'b01; wa[0] = 6'd12; wd[0] = 32'h55; ra[0] = 6'd12;
    tick();
    idle();
    #1;
    check("x12_data", rdata1[31:0], 32'h55);
    check("x12_busy", rbusy1[0], 1'b1);
    check("x12_cnt", cnt1, 1);
    tick();

    mark = 1; maddr = 6'd4; tick();
    maddr = 6'd5; tick();
    maddr = 6'd34; tick();
    ra[0] = 6'd4; ra[1] = 6'd5; ra[2] = 6'd34;
    flush = 1; maddr = 6'd6;
    tick();
    idle();
    #1;
    check("flush_cnt", cnt1, 0);
    check("flush_busy", rbusy1, 3'b000);
    ra[0] = 6'd6;
    tick();

    mark = 1; maddr = 6'd9;
    tick();
    idle();
    ra[0] = 6'd7; ra[1] = 6'd3; ra[2] = 6'd33;
    #1;
    check("pre_rst_x7", rdata0[31:0], 32'hDEADBEEF);
    rst_n = 0;
    #1;
    check("rst_rdata_byp", rdata1, 96'h0);
    check("rst_rdata_nob", rdata0, 96'h0);
    check("rst_busy", {rbusy1, rbusy0}, 6'h0);
    check("rst_cnt_byp", cnt1, 0);
    check("rst_cnt_nob", cnt0, 0);
    model_reset();
    @(posedge clk);
    #1 rst_n = 1;
    tick();

    for (int c = 0; c < 400; c++) begin
      for (int k = 0; k < 3; k++) ra[k] = rnd_addr();
      for (int p = 0; p < 2; p++) begin
        wa[p] = rnd_addr();
        wd[p] = $urandom;
      end
      we = 2'($urandom);
      mark = 1'($urandom);
      maddr = rnd_addr();
      flush = ($urandom_range(0, 15) == 0);
      tick();
    end
    idle();
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
